sram_1rw1r_param: RTL

//  Parametrised single-clock 1RW+1R behavioural SRAM, next generation of the 32x1024 OpenRAM model.

---
 rtl/sram_1rw1r_param.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sram_1rw1r_param.sv
// Single-clock 1RW + 1R behavioural SRAM with zero-fill init sequencer, registered read
// valids, same-address read-during-write forwarding and sticky error reporting.
module sram_1rw1r_param #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int MASK_GRAN   = 8,
  parameter int NUM_WMASKS  = DATA_WIDTH / MASK_GRAN,
  parameter int ADDR_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter bit INIT_ZERO   = 1'b1,
  parameter bit WRITE_FIRST = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  init_done_o,
  input  logic                  req0_i,
  input  logic                  we0_i,
  input  logic [NUM_WMASKS-1:0] wmask0_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  output logic                  rvalid0_o,
  input  logic                  req1_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic                  rvalid1_o,
  output logic                  collision_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_PEND,
    ST_READY
  } state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_init_cnt;
  logic                  r_init_done;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;
  logic                  r_rvalid0;
  logic                  r_rvalid1;
  logic                  r_collision;
  logic                  r_err;

  logic                  w_in0;
  logic                  w_in1;
  logic                  w_wr0;
  logic                  w_rd0;
  logic                  w_rd1;
  logic                  w_coll;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_old0;
  logic [DATA_WIDTH-1:0] w_old1;
  logic [DATA_WIDTH-1:0] w_fwd1;

  // Out-of-range addresses are possible only when DEPTH is not a power of two.
  assign w_in0  = ({1'b0, addr0_i} < DEPTH_EXT);
  assign w_in1  = ({1'b0, addr1_i} < DEPTH_EXT);

  assign w_wr0  = r_init_done & req0_i &  we0_i & w_in0;
  assign w_rd0  = r_init_done & req0_i & ~we0_i;
  assign w_rd1  = r_init_done & req1_i;
  assign w_coll = r_init_done & req0_i & we0_i & req1_i & w_in0 & w_in1 & (addr0_i == addr1_i);
  assign w_err  = (~r_init_done & (req0_i | req1_i)) |
                  ( r_init_done & ((req0_i & ~w_in0) | (req1_i & ~w_in1)));

  assign w_old0 = w_in0 ? r_mem[addr0_i] : '0;
  assign w_old1 = w_in1 ? r_mem[addr1_i] : '0;

  // Port1 forwarding: on a same-address write, masked lanes take the incoming data.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_fwd1 = w_old1;
    if (WRITE_FIRST && w_coll) begin
      for (int k = 0; k < NUM_WMASKS; k++) begin
        if (wmask0_i[k]) begin
          w_fwd1[k*MASK_GRAN +: MASK_GRAN] = wdata0_i[k*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  // NOTE: the array has no reset; a reset port on every word would defeat SRAM mapping,
  // so clearing is done by the init sequencer instead.
  always_ff @(posedge clk_i) begin
    if (r_state == ST_INIT) begin
      r_mem[r_init_cnt] <= '0;
    end else if (w_wr0) begin
      for (int k = 0; k < NUM_WMASKS; k++) begin
        if (wmask0_i[k]) begin
          r_mem[addr0_i][k*MASK_GRAN +: MASK_GRAN] <= wdata0_i[k*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      r_state     <= INIT_ZERO ? ST_INIT : ST_PEND;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_init_cnt == LAST_ADDR) begin
            r_state     <= ST_READY;
            r_init_done <= 1'b1;
          end else begin
            r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
          end
        end
        ST_PEND: begin
          r_state     <= ST_READY;
          r_init_done <= 1'b1;
        end
        default: begin
          r_state <= ST_READY;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_collision <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_rvalid0   <= w_rd0;
      r_rvalid1   <= w_rd1;
      r_collision <= w_coll;
      if (w_rd0) begin
        r_rdata0 <= w_old0;
      end
      if (w_rd1) begin
        r_rdata1 <= w_fwd1;
      end
      if (w_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign init_done_o = r_init_done;
  assign rdata0_o    = r_rdata0;
  assign rdata1_o    = r_rdata1;
  assign rvalid0_o   = r_rvalid0;
  assign rvalid1_o   = r_rvalid1;
  assign collision_o = r_collision;
  assign err_o       = r_err;

endmodule
